// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, reset vector default and canonical NOP.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_LOAD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] INST_NOP      = 32'h0000_0013;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: redirect beats hold beats sequential +4.
// Also flags redirect targets that are not word aligned.
module pc_next_sel #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            hold_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            misalign_o
);

  always_comb begin
    pc_next_o  = pc_i + XLEN'(4);
    misalign_o = 1'b0;
    if (redirect_valid_i) begin
      // low bits are dropped so fetch always stays word aligned
      pc_next_o  = {redirect_target_i[XLEN-1:2], 2'b00};
      misalign_o = |redirect_target_i[1:0];
    end else if (hold_i) begin
      pc_next_o = pc_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous imem,
// handles stall/redirect/halt and an in-domain program-load mode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ADDR_W    = 14,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [XLEN-1:0]   imem_wdata,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              upg_rst,
  input  logic              upg_wen,
  input  logic [ADDR_W-1:0] upg_adr,
  input  logic [XLEN-1:0]   upg_dat,
  input  logic              upg_done,
  output logic [XLEN-1:0]   inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_valid,
  output logic [XLEN-1:0]   pc_out,
  output logic              misalign_err,
  output logic [1:0]        state_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            vld_q, vld_d;
  logic            stalled_q, stalled_d;
  logic            mis_q, mis_d;

  logic            load_req;
  logic            in_load;
  logic [XLEN-1:0] pc_nxt;
  logic            tgt_mis;
  logic [XLEN-1:0] inst_raw;

  assign load_req = upg_rst & ~upg_done;
  assign in_load  = (state_q == ST_LOAD);

  pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
    .pc_i              (pc_q),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .hold_i            (stall | halt_req),
    .pc_next_o         (pc_nxt),
    .misalign_o        (tgt_mis)
  );

  // Once stalled, imem_rdata tracks the held PC, not inst_pc, so show the captured word.
  assign inst_raw = stalled_q ? hold_q : imem_rdata;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_pc_d = inst_pc_q;
    hold_d    = hold_q;
    vld_d     = vld_q;
    stalled_d = 1'b0;
    mis_d     = mis_q;
    if (load_req) begin
      state_d = ST_LOAD;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          vld_d = 1'b0;
          if (upg_done) begin
            state_d = ST_RUN;
            pc_d    = RESET_VEC;
          end
        end
        ST_HALT: begin
          vld_d = 1'b0;
          if (resume) state_d = ST_RUN;
        end
        default: begin
          pc_d = pc_nxt;
          if (tgt_mis) mis_d = 1'b1;
          if (redirect_valid || halt_req) begin
            vld_d = 1'b0;
          end else if (stall) begin
            stalled_d = 1'b1;
            hold_d    = inst_raw;
          end else begin
            inst_pc_d = pc_q;
            vld_d     = 1'b1;
          end
          if (halt_req) state_d = ST_HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_VEC;
      inst_pc_q <= RESET_VEC;
      hold_q    <= '0;
      vld_q     <= 1'b0;
      stalled_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_pc_q <= inst_pc_d;
      hold_q    <= hold_d;
      vld_q     <= vld_d;
      stalled_q <= stalled_d;
      mis_q     <= mis_d;
    end
  end

  // Uploader owns the memory port in LOAD; fetch owns it otherwise.
  assign imem_addr  = in_load ? upg_adr : pc_q[ADDR_W+1:2];
  assign imem_we    = in_load & upg_wen;
  assign imem_wdata = in_load ? upg_dat : '0;

  // A load request kills the in-flight instruction in the same cycle.
  assign inst_valid   = vld_q & ~load_req;
  assign inst         = inst_valid ? inst_raw : '0;
  assign inst_pc      = inst_pc_q;
  assign pc_out       = pc_q;
  assign misalign_err = mis_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for run/stall/redirect/halt,
// hand sequences for program load and asynchronous reset.
module tb_fetch_unit;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall, redirect_valid, halt_req, resume;
  logic [XLEN-1:0]   redirect_target;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_we;
  logic [XLEN-1:0]   imem_wdata, imem_rdata;
  logic              upg_rst, upg_wen, upg_done;
  logic [ADDR_W-1:0] upg_adr;
  logic [XLEN-1:0]   upg_dat;
  logic [XLEN-1:0]   inst, inst_pc, pc_out;
  logic              inst_valid, misalign_err;
  logic [1:0]        state_o;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RESET_VEC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halt_req(halt_req), .resume(resume),
    .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata), .upg_rst(upg_rst), .upg_wen(upg_wen),
    .upg_adr(upg_adr), .upg_dat(upg_dat), .upg_done(upg_done),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .pc_out(pc_out),
    .misalign_err(misalign_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory, preset to mem[i] = i while in reset.
  logic [XLEN-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < (1<<ADDR_W); i++) mem[i] <= i;
    end else if (imem_we) begin
      mem[imem_addr] <= imem_wdata;
    end
    imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic            st, rv, hr, rs;
    logic [XLEN-1:0] tg;
    logic [XLEN-1:0] e_pc, e_ipc, e_inst;
    logic            e_vld, e_mis;
    logic [1:0]      e_st;
  } vec_t;

  function automatic vec_t v(input logic st, rv, input logic [XLEN-1:0] tg, input logic hr, rs,
                             input logic [XLEN-1:0] e_pc, e_ipc, e_inst,
                             input logic e_vld, input logic [1:0] e_st, input logic e_mis);
    vec_t r;
    r.st = st; r.rv = rv; r.tg = tg; r.hr = hr; r.rs = rs;
    r.e_pc = e_pc; r.e_ipc = e_ipc; r.e_inst = e_inst;
    r.e_vld = e_vld; r.e_st = e_st; r.e_mis = e_mis;
    return r;
  endfunction

  vec_t tbl[$];
  logic [XLEN-1:0] ld_dat [4];

  initial begin
    //                 st rv tg            hr rs  pc            ipc           inst     vld st mis
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 32'h4,        32'h0,        32'h0,    1, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 32'h8,        32'h4,        32'h1,    1, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 32'hC,        32'h8,        32'h2,    1, 0, 0));
    tbl.push_back(v(1, 0, 32'h0,        0, 0, 32'hC,        32'h8,        32'h2,    1, 0, 0));
    tbl.push_back(v(1, 0, 32'h0,        0, 0, 32'hC,        32'h8,        32'h2,    1, 0, 0));
    tbl.push_back(v(1, 0, 32'h0,        0, 0, 32'hC,        32'h8,        32'h2,    1, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 32'h10,       32'hC,        32'h3,    1, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 32'h14,       32'h10,       32'h4,    1, 0, 0));
    tbl.push_back(v(0, 1, 32'h40,       0, 0, 32'h40,       32'h0,        32'h0,    0, 0, 0));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 32'h44,       32'h40,       32'h10,   1, 0, 0));
    tbl.push_back(v(0, 1, 32'h42,       0, 0, 32'h40,       32'h0,        32'h0,    0, 0, 1));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 32'h44,       32'h40,       32'h10,   1, 0, 1));
    tbl.push_back(v(1, 1, 32'h8,        0, 0, 32'h8,        32'h0,        32'h0,    0, 0, 1));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 32'hC,        32'h8,        32'h2,    1, 0, 1));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 32'h10,       32'hC,        32'h3,    1, 0, 1));
    tbl.push_back(v(0, 0, 32'h0,        1, 0, 32'h10,       32'h0,        32'h0,    0, 1, 1));
    tbl.push_back(v(0, 1, 32'h80,       0, 0, 32'h10,       32'h0,        32'h0,    0, 1, 1));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 32'h10,       32'h0,        32'h0,    0, 1, 1));
    tbl.push_back(v(1, 0, 32'h0,        0, 0, 32'h10,       32'h0,        32'h0,    0, 1, 1));
    tbl.push_back(v(0, 0, 32'h0,        1, 0, 32'h10,       32'h0,        32'h0,    0, 1, 1));
    tbl.push_back(v(0, 0, 32'h0,        0, 1, 32'h10,       32'h0,        32'h0,    0, 0, 1));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 32'h14,       32'h10,       32'h4,    1, 0, 1));
    tbl.push_back(v(0, 1, 32'h20,       1, 0, 32'h20,       32'h0,        32'h0,    0, 1, 1));
    tbl.push_back(v(0, 0, 32'h0,        0, 1, 32'h20,       32'h0,        32'h0,    0, 0, 1));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 32'h24,       32'h20,       32'h8,    1, 0, 1));
    tbl.push_back(v(0, 1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 32'h0,        32'h0,    0, 0, 1));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 32'h0,        32'hFFFFFFFC, 32'h3FFF, 1, 0, 1));
    tbl.push_back(v(0, 0, 32'h0,        0, 0, 32'h4,        32'h0,        32'h0,    1, 0, 1));

    ld_dat[0] = 32'hA0A0_0001; ld_dat[1] = 32'hB0B0_0002;
    ld_dat[2] = 32'hC0C0_0003; ld_dat[3] = 32'hD0D0_0004;

    rst_n = 1'b0; stall = 0; redirect_valid = 0; redirect_target = '0;
    halt_req = 0; resume = 0; upg_rst = 0; upg_wen = 0; upg_adr = '0;
    upg_dat = '0; upg_done = 0;
    step(); step();
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_we", 32'(imem_we), 32'h0);
    chk("rst_state", 32'(state_o), 32'h0);
    chk("rst_mis", 32'(misalign_err), 32'h0);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      stall = tbl[k].st; redirect_valid = tbl[k].rv; redirect_target = tbl[k].tg;
      halt_req = tbl[k].hr; resume = tbl[k].rs;
      step();
      chk($sformatf("v%0d_pc", k), pc_out, tbl[k].e_pc);
      chk($sformatf("v%0d_valid", k), 32'(inst_valid), 32'(tbl[k].e_vld));
      chk($sformatf("v%0d_state", k), 32'(state_o), 32'(tbl[k].e_st));
      chk($sformatf("v%0d_mis", k), 32'(misalign_err), 32'(tbl[k].e_mis));
      if (tbl[k].e_vld) begin
        chk($sformatf("v%0d_inst_pc", k), inst_pc, tbl[k].e_ipc);
        chk($sformatf("v%0d_inst", k), inst, tbl[k].e_inst);
      end else begin
        chk($sformatf("v%0d_inst_zero", k), inst, 32'h0);
      end
    end
    stall = 0; redirect_valid = 0; halt_req = 0; resume = 0;

    // Program load: abort is immediate, then four writes, then restart at PC 0.
    chk("run_wdata_zero", imem_wdata, 32'h0);
    upg_rst = 1;
    #1;
    chk("load_abort_valid", 32'(inst_valid), 32'h0);
    step();
    chk("load_state", 32'(state_o), 32'h2);
    chk("load_we_idle", 32'(imem_we), 32'h0);
    for (int i = 0; i < 4; i++) begin
      upg_wen = 1; upg_adr = ADDR_W'(i); upg_dat = ld_dat[i];
      #1;
      chk($sformatf("load%0d_we", i), 32'(imem_we), 32'h1);
      chk($sformatf("load%0d_addr", i), 32'(imem_addr), i);
      chk($sformatf("load%0d_wdata", i), imem_wdata, ld_dat[i]);
      step();
    end
    upg_wen = 0; halt_req = 1; redirect_valid = 1; redirect_target = 32'h100; stall = 1;
    #1;
    chk("load_we_low", 32'(imem_we), 32'h0);
    step();
    chk("load_ignore_state", 32'(state_o), 32'h2);
    chk("load_ignore_valid", 32'(inst_valid), 32'h0);
    chk("load_ignore_mis", 32'(misalign_err), 32'h1);
    halt_req = 0; redirect_valid = 0; stall = 0;
    upg_done = 1;
    step();
    chk("done_state", 32'(state_o), 32'h0);
    chk("done_pc", pc_out, 32'h0);
    chk("done_valid", 32'(inst_valid), 32'h0);
    chk("done_we", 32'(imem_we), 32'h0);
    upg_rst = 0; upg_done = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ldrun%0d_valid", i), 32'(inst_valid), 32'h1);
      chk($sformatf("ldrun%0d_inst_pc", i), inst_pc, 32'(4 * i));
      chk($sformatf("ldrun%0d_inst", i), inst, ld_dat[i]);
    end

    // Asynchronous reset while loading.
    upg_rst = 1; upg_wen = 1; upg_adr = 14'd5; upg_dat = 32'h5555_5555;
    step();
    chk("aload_state", 32'(state_o), 32'h2);
    chk("aload_we", 32'(imem_we), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 32'h0);
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_inst_pc", inst_pc, 32'h0);
    chk("arst_we", 32'(imem_we), 32'h0);
    chk("arst_wdata", imem_wdata, 32'h0);
    chk("arst_mis", 32'(misalign_err), 32'h0);
    upg_rst = 0; upg_wen = 0;
    #1;
    chk("arst_valid", 32'(inst_valid), 32'h0);
    chk("arst_inst", inst, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
